mux16_rr_arbiter: RTL
=====================

Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit three-input operand/writeback mux.
- Three requesters (A, B, C) compete for the mux path. The block grants one at a time and drives the mux 2-bit select: A=00, B=01, C=10.
- Grants are held for bursts of up to MAX_HOLD transfers, with a valid/ready handshake to the downstream consumer.
- Sits between the requesting units and the mux select input in the SISC datapath.

Parameters:
- MAX_HOLD, 4, maximum accepted transfers per grant before forced rotation. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- req  input  3  request vector: bit0=A, bit1=B, bit2=C.
- out_ready  input  1  downstream accepts the mux output this cycle.
- gnt  output  3  one-hot registered grant, same bit order as req.
- sel  output  2  registered mux select: 00=A, 01=B, 10=C. Never 11.
- out_valid  output  1  mux output is valid for the current holder.
- busy  output  1  a grant is held.

Behaviour:
- Interface: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: gnt=000, sel=00, busy=0, out_valid=0, hold_cnt=0, last-grant pointer=C (so A has top priority after reset). Reset asserted mid-burst clears everything immediately, with no completion of the transfer.
- States:
  - IDLE: gnt=000, busy=0.
  - GRANT: gnt one-hot, busy=1.
- IDLE -> GRANT:
  - Taken at the first clk edge where req!=000.
  - Winner chosen round-robin, starting from the requester after the last-grant pointer (A->B->C->A).
  - gnt and sel are registered, so they become valid one cycle after req is sampled (1-cycle grant latency).
- out_valid = busy AND req[holder], combinational from the registered grant.
- Transfer: xfer = out_valid AND out_ready. Each xfer increments hold_cnt.
- Release occurs at the clk edge where either:
  - req[holder] is sampled low, or
  - xfer occurs with hold_cnt==MAX_HOLD-1 (the MAX_HOLD-th transfer).
- On release:
  - The last-grant pointer is updated to the holder and hold_cnt is cleared.
  - If any req bit is set (the holder included), re-arbitrate in the same edge and go straight to the new GRANT with no idle bubble.
  - Otherwise go to IDLE with sel=00.
- Stall: while out_ready=0, the grant is held indefinitely and hold_cnt is frozen.
- The holder may be re-granted immediately after a forced rotation only if no other requester is active.
- Requests that rise during a grant wait for the next arbitration. No preemption.
- sel always matches gnt. sel never equals 11, in any state.

Optional Feature:
- Macro: MUX16_FIXED_PRIO_EN.
- When defined: arbitration is fixed priority A>B>C. The last-grant pointer is removed. The MAX_HOLD rotation still forces a release, but re-arbitration uses fixed priority, so A may immediately regain the grant.
- When undefined: round-robin as described above (default build).

Test Plan:
- Reset then req=111, out_ready=1, MAX_HOLD=4 -> gnt=001/sel=00 for 4 transfers, then 010/01 for 4, then 100/10 for 4, then 001 again. No gap cycles between grants.
- req=010 held, out_ready=0 for 10 cycles, then 1 -> gnt=010 and sel=01 held throughout, out_valid=1, hold_cnt stays 0. Release after 4 accepted transfers, then re-grant to B (only requester).
- Grant to A, A drops req after 2 transfers while req[2]=1 -> next edge gnt=100, sel=10, out_valid=1. No IDLE cycle.
- Single req=001 pulse one cycle -> gnt=001 the following cycle with out_valid=0 (req low), then release to IDLE: gnt=000, busy=0, sel=00.
- Assert rst mid-burst (B holding, hold_cnt=2) -> asynchronously gnt=000, sel=00, busy=0. After deassert with req=111, A granted first.
- With MUX16_FIXED_PRIO_EN, req=111, MAX_HOLD=2 -> A granted, rotation after 2 transfers, A re-granted. B and C are never granted while A requests.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 16-bit three-input mux (A/B/C).
// Define MUX16_FIXED_PRIO_EN for fixed A>B>C priority instead of round-robin.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       out_ready,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state, state_n;
    logic [2:0] gnt_n;
    logic [1:0] sel_n;
    logic [3:0] hold_cnt, hold_n;
    logic       holder_req, xfer, release_now;
    logic [1:0] pick;

`ifdef MUX16_FIXED_PRIO_EN
    function automatic logic [1:0] arb(input logic [2:0] r);
        if (r[0])      arb = 2'd0;
        else if (r[1]) arb = 2'd1;
        else           arb = 2'd2;
    endfunction
`else
    logic [1:0] last, last_n;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        nxt = (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search starts just after the previous holder and wraps back to it last.
    function automatic logic [1:0] arb(input logic [2:0] r, input logic [1:0] lst);
        logic [1:0] i1, i2;
        i1 = nxt(lst);
        i2 = nxt(i1);
        if (r[i1])      arb = i1;
        else if (r[i2]) arb = i2;
        else            arb = lst;
    endfunction
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 3'b000;
            sel      <= 2'b00;
            hold_cnt <= 4'd0;
`ifndef MUX16_FIXED_PRIO_EN
            last     <= 2'd2;
`endif
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            hold_cnt <= hold_n;
`ifndef MUX16_FIXED_PRIO_EN
            last     <= last_n;
`endif
        end
    end

    assign holder_req  = |(gnt & req);
    assign xfer        = out_valid & out_ready;
    assign release_now = (state == GRANT) &&
                         (!holder_req || (xfer && hold_cnt == 4'(MAX_HOLD - 1)));

    // Next-state logic
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        hold_n  = hold_cnt;
`ifdef MUX16_FIXED_PRIO_EN
        pick    = arb(req);
`else
        last_n  = last;
        // On release the holder becomes the new pointer in the same edge.
        pick    = arb(req, release_now ? sel : last);
        if (release_now) last_n = sel;
`endif
        if (release_now)
            hold_n = 4'd0;
        else if (xfer)
            hold_n = hold_cnt + 4'd1;

        if (state == IDLE || release_now) begin
            if (|req) begin
                state_n = GRANT;
                gnt_n   = 3'b001 << pick;
                sel_n   = pick;
            end else begin
                state_n = IDLE;
                gnt_n   = 3'b000;
                sel_n   = 2'b00;
            end
        end
    end

    // Outputs
    always_comb begin
        busy      = (state == GRANT);
        out_valid = busy & holder_req;
    end

endmodule
